// File: rtl/shift_tx_controller.sv
// Framed serial transmitter sequencer for an external 8-bit shift_register.
// A byte accepted on tx_valid/tx_ready is loaded into the shift register.
// It is then sent as: start bit (0), 8 data bits, stop bit (1).
// Each bit lasts CLKS_PER_BIT clock cycles.
//
// Handshake: a byte is transferred in the cycle where tx_valid && tx_ready
// is high. tx_ready is high only in IDLE and outside reset. The source must
// hold tx_data stable until that cycle. tx_valid is ignored while busy.
module shift_tx_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [1:0] sr_mode,
    output logic [7:0] sr_data_p,
    output logic       sr_data_s,
    input  logic [7:0] sr_q,
    output logic       serial_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [1:0] MODE_SHIFT = (MSB_FIRST != 1'b0) ? MODE_LEFT : MODE_RIGHT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] bit_timer_q, bit_timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          timer_end;
    logic          accept;
    logic          line_bit;
    logic          sr_q_unused;

    // Only the bit on the shifting edge reaches the line; the rest are observed by the shift register alone.
    assign sr_q_unused = ^sr_q[6:1];

    assign sr_data_p = tx_data;
    assign sr_data_s = 1'b1;
    assign timer_end = (bit_timer_q == TIMER_MAX);
    assign tx_ready  = (state_q == IDLE) && !reset;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;
    assign line_bit  = (MSB_FIRST != 1'b0) ? sr_q[7] : sr_q[0];

    // Frame sequencing: next state, counters, shift register command and done pulse.
    always_comb begin
        state_d     = state_q;
        bit_timer_d = bit_timer_q;
        bit_cnt_d   = bit_cnt_q;
        sr_mode     = MODE_HOLD;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_mode     = MODE_LOAD;
                    bit_timer_d = '0;
                    bit_cnt_d   = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (timer_end) begin
                    bit_timer_d = '0;
                    state_d     = DATA;
                end else begin
                    bit_timer_d = bit_timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_end) begin
                    // Shift on the last cycle of the period so the next bit appears at the period start.
                    sr_mode     = MODE_SHIFT;
                    bit_timer_d = '0;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    bit_timer_d = bit_timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_end) begin
                    done        = !reset;
                    bit_timer_d = '0;
                    state_d     = IDLE;
                end else begin
                    bit_timer_d = bit_timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level decoded from registered state and shift register contents only.
    always_comb begin
        serial_out = 1'b1;
        case (state_q)
            START:   serial_out = 1'b0;
            DATA:    serial_out = line_bit;
            default: serial_out = 1'b1;
        endcase
    end

    // State and counter registers; reset aborts any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_timer_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_timer_q <= bit_timer_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_tx_controller.sv
// Bench for shift_tx_controller: an MSB-first and an LSB-first instance (N=4)
// share stimulus, each driving its own behavioural shift register.
module tb_shift_tx_controller;

    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic       m_ready, l_ready;
    logic [1:0] m_mode, l_mode;
    logic [7:0] m_dp, l_dp;
    logic       m_ds, l_ds;
    logic [7:0] m_sr, l_sr;
    logic       m_line, l_line;
    logic       m_busy, l_busy;
    logic       m_done, l_done;
    logic [1:0] m_state, l_state;

    int checks;
    int errors;

    shift_tx_controller #(.CLKS_PER_BIT(N), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(m_ready), .sr_mode(m_mode), .sr_data_p(m_dp), .sr_data_s(m_ds),
        .sr_q(m_sr), .serial_out(m_line), .busy(m_busy), .done(m_done),
        .state_dbg(m_state)
    );

    shift_tx_controller #(.CLKS_PER_BIT(N), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(l_ready), .sr_mode(l_mode), .sr_data_p(l_dp), .sr_data_s(l_ds),
        .sr_q(l_sr), .serial_out(l_line), .busy(l_busy), .done(l_done),
        .state_dbg(l_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural shift_register for the MSB-first instance
    always @(posedge clock) begin
        if (reset) m_sr <= 8'h00;
        else case (m_mode)
            2'b01:   m_sr <= {m_sr[6:0], m_ds};
            2'b10:   m_sr <= {m_ds, m_sr[7:1]};
            2'b11:   m_sr <= m_dp;
            default: m_sr <= m_sr;
        endcase
    end

    // Behavioural shift_register for the LSB-first instance
    always @(posedge clock) begin
        if (reset) l_sr <= 8'h00;
        else case (l_mode)
            2'b01:   l_sr <= {l_sr[6:0], l_ds};
            2'b10:   l_sr <= {l_ds, l_sr[7:1]};
            2'b11:   l_sr <= l_dp;
            default: l_sr <= l_sr;
        endcase
    end

    // Accept cycle T0: drive byte, then check the load command.
    task automatic accept_byte(input logic [7:0] b, input string tag);
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        #1;
        checks++;
        if (m_ready !== 1'b1 || l_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept tx_ready got %b/%b exp 1/1", tag, m_ready, l_ready);
        end
        checks++;
        if (m_mode !== 2'b11 || l_mode !== 2'b11) begin
            errors++;
            $display("FAIL %s accept sr_mode got %b/%b exp 11/11", tag, m_mode, l_mode);
        end
    endtask

    // Cycles T0+1..T0+40 of a frame carrying byte b.
    // vmode: 0 drop tx_valid, 1 hold tx_valid, 2 toggle tx_valid with junk data.
    task automatic run_frame(input logic [7:0] b, input logic [7:0] next_data,
                             input int vmode, input string tag);
        int p;
        logic e_m_line, e_l_line, e_done;
        logic [1:0] e_m_mode, e_l_mode, e_state;
        for (int k = 1; k <= 10 * N; k++) begin
            @(negedge clock);
            if (k == 1) begin
                tx_data = next_data;
                if (vmode == 0) tx_valid = 1'b0;
            end
            if (vmode == 2) begin
                tx_valid = (k == 10 * N) ? 1'b0 : ~tx_valid;
                tx_data  = 8'($urandom_range(0, 255));
            end
            #1;
            p = (k - 1) / N;
            if (p == 0) begin
                e_m_line = 1'b0; e_l_line = 1'b0;
            end else if (p == 9) begin
                e_m_line = 1'b1; e_l_line = 1'b1;
            end else begin
                e_m_line = b[8 - p];
                e_l_line = b[p - 1];
            end
            if (k >= 2 * N && k <= 9 * N && (k % N) == 0) begin
                e_m_mode = 2'b01; e_l_mode = 2'b10;
            end else begin
                e_m_mode = 2'b00; e_l_mode = 2'b00;
            end
            e_done  = (k == 10 * N);
            e_state = (k <= N) ? 2'd1 : ((k <= 9 * N) ? 2'd2 : 2'd3);

            checks++;
            if (m_line !== e_m_line) begin
                errors++;
                $display("FAIL %s k=%0d msb serial_out got %b exp %b", tag, k, m_line, e_m_line);
            end
            checks++;
            if (l_line !== e_l_line) begin
                errors++;
                $display("FAIL %s k=%0d lsb serial_out got %b exp %b", tag, k, l_line, e_l_line);
            end
            checks++;
            if (m_mode !== e_m_mode || l_mode !== e_l_mode) begin
                errors++;
                $display("FAIL %s k=%0d sr_mode got %b/%b exp %b/%b", tag, k, m_mode, l_mode, e_m_mode, e_l_mode);
            end
            checks++;
            if (m_done !== e_done || l_done !== e_done) begin
                errors++;
                $display("FAIL %s k=%0d done got %b/%b exp %b", tag, k, m_done, l_done, e_done);
            end
            checks++;
            if (m_state !== e_state || m_busy !== 1'b1 || m_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s k=%0d state/busy/ready got %0d/%b/%b exp %0d/1/0", tag, k, m_state, m_busy, m_ready, e_state);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (m_ready !== 1'b0 || l_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d tx_ready got %b/%b exp 0/0", i, m_ready, l_ready);
            end
        end
        @(negedge clock);
        reset    = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++;
        if (m_ready !== 1'b1 || m_line !== 1'b1 || m_mode !== 2'b00 ||
            m_busy !== 1'b0 || m_done !== 1'b0 || m_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release msb ready/line/mode/busy/done/state got %b/%b/%b/%b/%b/%0d exp 1/1/00/0/0/0",
                     m_ready, m_line, m_mode, m_busy, m_done, m_state);
        end
        checks++;
        if (l_ready !== 1'b1 || l_line !== 1'b1 || l_mode !== 2'b00 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release lsb ready/line/mode/busy got %b/%b/%b/%b exp 1/1/00/0",
                     l_ready, l_line, l_mode, l_busy);
        end
    endtask

    // 0xA5 on both instances: MSB-first and LSB-first frames.
    task automatic test_frame_a5();
        accept_byte(8'hA5, "a5");
        run_frame(8'hA5, 8'hA5, 0, "a5");
    endtask

    // 0x00 then 0xFF with tx_valid held; second accept lands on T0+41.
    task automatic test_back_to_back();
        accept_byte(8'h00, "b2b0");
        run_frame(8'h00, 8'hFF, 1, "b2b0");
        @(negedge clock);
        #1;
        checks++;
        if (m_ready !== 1'b1 || m_mode !== 2'b11 || l_mode !== 2'b11 ||
            m_line !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b second_accept ready/mode/line/busy got %b/%b/%b/%b exp 1/11/1/0",
                     m_ready, m_mode, m_line, m_busy);
        end
        run_frame(8'hFF, 8'hFF, 0, "b2b1");
    endtask

    // Reset at T0+17 aborts the frame; a fresh byte then goes out intact.
    task automatic test_reset_mid_frame();
        accept_byte(8'hC3, "abort");
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 1) tx_valid = 1'b0;
            if (k == 17) reset = 1'b1;
            #1;
            checks++;
            if (m_done !== 1'b0 || l_done !== 1'b0) begin
                errors++;
                $display("FAIL abort k=%0d done got %b/%b exp 0/0", k, m_done, l_done);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (m_state !== 2'd0 || l_state !== 2'd0 || m_line !== 1'b1 || l_line !== 1'b1 ||
            m_done !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort after_reset state/line/done/busy/ready got %0d/%b/%b/%b/%b exp 0/1/0/0/1",
                     m_state, m_line, m_done, m_busy, m_ready);
        end
        accept_byte(8'h3C, "after_abort");
        run_frame(8'h3C, 8'h3C, 0, "after_abort");
    endtask

    // tx_valid toggling while busy must not reload or disturb the frame.
    task automatic test_valid_toggle();
        accept_byte(8'h96, "toggle");
        run_frame(8'h96, 8'h96, 2, "toggle");
        @(negedge clock);
        #1;
        checks++;
        if (m_state !== 2'd0 || m_mode !== 2'b00 || m_line !== 1'b1) begin
            errors++;
            $display("FAIL toggle idle_after state/mode/line got %0d/%b/%b exp 0/00/1",
                     m_state, m_mode, m_line);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_toggle();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
